// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/LS requester ports and the SRAM port of the arbiter.
interface mem_port_arbiter_if #(parameter int AW = 10, parameter int DW = 32);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic            ls_req;
    logic            ls_we;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_be;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [DW-1:0]   ls_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IF/LS arbitration of a single-port SRAM with read-data routing.
module mem_port_arbiter #(parameter int AW = 10, parameter int DW = 32) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic [15:0]         conflict_cnt
);
    typedef enum logic {IF_P, LS_P} port_e;
    port_e last_q, last_d;
    logic  if_g, ls_g, if_rv_q, ls_rv_q;
    // on conflict the port that did not win last time goes first
    always_comb begin
        if_g           = !reset & bus.if_req & (!bus.ls_req | last_q == LS_P);
        ls_g           = !reset & bus.ls_req & (!bus.if_req | last_q == IF_P);
        last_d         = if_g ? IF_P : ls_g ? LS_P : last_q;
        bus.if_gnt     = if_g;
        bus.ls_gnt     = ls_g;
        bus.mem_en     = if_g | ls_g;
        bus.mem_we     = ls_g & bus.ls_we;
        bus.mem_addr   = if_g ? bus.if_addr : ls_g ? bus.ls_addr : '0;
        bus.mem_be     = if_g ? '1 : ls_g ? bus.ls_be : '0;
        bus.mem_wdata  = ls_g ? bus.ls_wdata : '0;
        bus.if_rvalid  = if_rv_q;
        bus.ls_rvalid  = ls_rv_q;
        bus.if_rdata   = if_rv_q ? bus.mem_rdata : '0;
        bus.ls_rdata   = ls_rv_q ? bus.mem_rdata : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q       <= LS_P;
            if_rv_q      <= 1'b0;
            ls_rv_q      <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            last_q  <= last_d;
            if_rv_q <= if_g;
            ls_rv_q <= ls_g & !bus.ls_we;
            if (bus.if_req && bus.ls_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port instruction/data SRAM between the core's instruction-fetch (IF) port and its load/store (LS) port. Each cycle it grants at most one requester, drives the SRAM, and routes the one-cycle-late read data back to the owner. Round-robin on conflict; it also counts conflict cycles for performance bring-up in the core testbench.

## Interface
- AW, 10, SRAM word-address width
- DW, 32, data width (multiple of 8)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request, held until granted
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- ls_req  in  1  load/store request, held until granted
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  load/store word address
- ls_wdata  in  DW  store data
- ls_be  in  DW/8  store byte enables
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid
- ls_rdata  out  DW  load data
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_be  out  DW/8  SRAM byte enables
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid the cycle after a read access
- conflict_cnt  out  16  saturating count of cycles with both requests high

## Operation
- Grant is combinational: only if_req -> if_gnt; only ls_req -> ls_gnt; both -> requester not equal to `last` wins.
- `last` register (IF/LS): updated to the winner on every grant; reset value LS, so IF wins the first conflict.
- At most one of if_gnt/ls_gnt high in any cycle; neither high when no request.
- mem_en = if_gnt | ls_gnt. On IF grant: mem_we=0, mem_addr=if_addr, mem_be=all ones, mem_wdata=0. On LS grant: mem_we=ls_we, mem_addr=ls_addr, mem_be=ls_be, mem_wdata=ls_wdata. When idle: mem_we=0, mem_addr/mem_be/mem_wdata=0.
- Response owner register: on a read grant (IF, or LS with ls_we=0), record owner; next cycle assert that port's rvalid for exactly one cycle.
- Stores produce no rvalid; ls_gnt is the store completion.
- if_rdata/ls_rdata = mem_rdata when own rvalid high, else 0.
- conflict_cnt increments by 1 each cycle if_req & ls_req; holds at 16'hFFFF (no wrap).
- Requester must keep req/addr/data stable until gnt; arbiter does not latch unaccepted requests.

## Timing
- Reset (async assert, sync-safe release): if_rvalid=0, ls_rvalid=0, rdata outputs=0, conflict_cnt=0, last=LS, owner cleared. Grants and mem_* follow inputs combinationally but reset forces if_gnt=ls_gnt=mem_en=0 while reset high.
- Read latency: gnt in cycle N -> rvalid in cycle N+1. Back-to-back reads every cycle supported (throughput 1/cycle).
- Reset asserted between grant and rvalid: the pending response is dropped; no rvalid after reset release.
- Continuous conflict: grants strictly alternate IF, LS, IF, LS...; no requester waits more than 1 cycle.
- Request dropped without grant (illegal) is ignored; no state change.
- Simultaneous LS store grant and IF-owned rvalid from prior cycle: both occur; no interaction.

## Test plan
- Reset: assert reset mid-run with a read in flight -> all outputs 0, conflict_cnt=0, no rvalid on release; first conflict after release grants IF.
- IF only: if_req=1 with addresses 0,1,2,3 over 4 cycles -> if_gnt=1 each cycle, mem_en=1/mem_we=0, if_rvalid at cycles 1-4 carrying SRAM model words 0-3.
- LS store then load: store 32'hDEADBEEF, be=4'b0011 to addr 5, then load addr 5 -> store gives ls_gnt, no ls_rvalid; load returns ls_rdata=32'h????BEEF per model (upper bytes unchanged).
- Sustained conflict: both req high for 6 cycles -> grants IF,LS,IF,LS,IF,LS; conflict_cnt=6; rvalids routed to matching port one cycle later.
- Saturation: force 65540 conflict cycles -> conflict_cnt stops at 16'hFFFF.
- Mixed idle: alternating idle cycles -> mem_en=0, mem_addr=0 in idle cycles, no spurious rvalid.
